// File: rtl/mux_rr_buffer_rtl.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin arbitration,
// a one-entry registered output buffer and a tri-state bus driver.
module mux_rr_buffer_rtl #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready,
  input  logic            oe,
  output logic [W-1:0]    out_bus
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic          grant_vld;
  logic          load_en;
  logic          in_xfer;
  logic [N-1:0]  rot_valid;
  logic [W-1:0]  grant_data;

  assign load_en = !out_valid || out_ready;

  // rot_valid[k] is channel (ptr+k) mod N, so the lowest set bit is the RR winner
  assign rot_valid = N'({in_valid, in_valid} >> ptr);

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (!mode) begin
      grant = sel;
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i)) grant_vld = in_valid[i];
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (rot_valid[k]) begin
          grant     = SW'((int'(ptr) + k) % N);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        in_ready[i] = rst_n && load_en && grant_vld;
        grant_data  = in_data[i*W +: W];
      end
    end
  end

  assign in_xfer = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
      ptr       <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_bus = (out_valid && oe) ? out_data : {W{1'bz}};

endmodule

// File: tb/tb_mux_rr_buffer_rtl.sv
// Bench for mux_rr_buffer_rtl: directed scenarios plus random traffic against a
// transaction-level model. Bus nets are pulled high so a released bus reads all ones.
module tb_mux_rr_buffer_rtl;
  localparam int N = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        oe = 1'b0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  tri1  [7:0]  out_bus;

  logic [1:0]  sel3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [23:0] in_data3 = '0;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  tri1  [7:0]  out_bus3;

  mux_rr_buffer_rtl #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready), .oe(oe),
    .out_bus(out_bus)
  );

  mux_rr_buffer_rtl #(.N(3), .W(W)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(sel3), .in_valid(in_valid3),
    .in_data(in_data3), .in_ready(in_ready3), .out_valid(out_valid3),
    .out_data(out_data3), .out_ch(out_ch3), .out_ready(1'b1), .oe(1'b1),
    .out_bus(out_bus3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  // Grant as the arbitration rules describe it: chosen channel, or first valid
  // channel scanning upward from the pointer with wrap-around.
  task automatic model_grant(output bit v, output int g);
    v = 1'b0;
    g = 0;
    if (!mode) begin
      g = int'(sel);
      v = in_valid[g];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!v && in_valid[c]) begin
          v = 1'b1;
          g = c;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_bus();
    return (m_valid && oe) ? m_data : 8'hFF;
  endfunction

  task automatic check_regs();
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_data", {24'b0, out_data}, {24'b0, m_data});
    chk("out_ch", {30'b0, out_ch}, m_ch);
    chk("out_bus", {24'b0, out_bus}, {24'b0, exp_bus()});
  endtask

  // One clock: check combinational outputs, clock, advance model, check registers.
  task automatic cycle();
    bit         v;
    int         g;
    logic [3:0] exp_rdy;
    bit         can_load;
    #1;
    model_grant(v, g);
    can_load = !m_valid || out_ready;
    exp_rdy  = (can_load && v) ? 4'(1 << g) : 4'b0;
    chk("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
    chk("out_bus_comb", {24'b0, out_bus}, {24'b0, exp_bus()});
    @(posedge clk);
    if (can_load && v) begin
      m_valid = 1'b1;
      m_data  = in_data[g*8 +: 8];
      m_ch    = g;
      m_ptr   = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_regs();
  endtask

  initial begin
    model_reset();
    // Reset held with all channels requesting
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    oe        = 1'b1;
    in_valid3 = 3'b111;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {28'b0, in_ready}, 32'h0);
    chk("rst_in_ready3", {29'b0, in_ready3}, 32'h0);
    check_regs();

    // First transfer after release, fixed select channel 2
    mode    = 1'b0;
    sel     = 2'd2;
    in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    rst_n   = 1'b1;
    cycle();
    chk("first_data", {24'b0, out_data}, 32'hA5);
    chk("first_ch", {30'b0, out_ch}, 32'd2);

    // Pointer is now 3: round-robin with channels 0 and 2 only
    mode     = 1'b1;
    in_valid = 4'b0101;
    in_data  = {8'h23, 8'h22, 8'h21, 8'h20};
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_skip_ch", {30'b0, out_ch}, (i % 2) * 2);
    end

    // Reset mid-operation discards the buffered word and clears the pointer
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_in_ready", {28'b0, in_ready}, 32'h0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness: all valid, full throughput
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_fair_ch", {30'b0, out_ch}, i % 4);
      chk("rr_fair_data", {24'b0, out_data}, 32'h10 + (i % 4));
    end

    // Backpressure holds the buffered word
    mode    = 1'b0;
    sel     = 2'd1;
    in_data = {8'h00, 8'h00, 8'h3C, 8'h00};
    cycle();
    out_ready = 1'b0;
    in_data   = {8'h00, 8'h00, 8'h77, 8'h00};
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", {28'b0, in_ready}, 32'h0);
      chk("bp_data", {24'b0, out_data}, 32'h3C);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_data", {24'b0, out_data}, 32'h77);
    chk("bp_release_valid", {31'b0, out_valid}, 32'h1);

    // Selected channel not valid: no grant, buffer drains
    in_valid = 4'b1101;
    cycle();
    chk("sel_invalid_valid", {31'b0, out_valid}, 32'h0);

    // Tri-state enable toggling on a held word
    sel      = 2'd0;
    in_valid = 4'b0001;
    in_data  = {8'h00, 8'h00, 8'h00, 8'h5A};
    cycle();
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    #1 chk("ts_on", {24'b0, out_bus}, 32'h5A);
    oe = 1'b0;
    #1 chk("ts_off", {24'b0, out_bus}, 32'hFF);
    oe = 1'b1;
    #1 chk("ts_on_again", {24'b0, out_bus}, 32'h5A);
    out_ready = 1'b1;
    cycle();
    chk("ts_empty", {24'b0, out_bus}, 32'hFF);

    // Three-channel instance: out-of-range select never grants
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    in_data3  = {8'hC2, 8'hC1, 8'hC0};
    @(negedge clk);
    chk("n3_oor_ready", {29'b0, in_ready3}, 32'h0);
    @(negedge clk);
    chk("n3_oor_valid", {31'b0, out_valid3}, 32'h0);
    chk("n3_oor_bus", {24'b0, out_bus3}, 32'hFF);
    sel3 = 2'd2;
    #1 chk("n3_sel2_ready", {29'b0, in_ready3}, 32'h4);
    @(negedge clk);
    chk("n3_sel2_data", {24'b0, out_data3}, 32'hC2);
    chk("n3_sel2_ch", {30'b0, out_ch3}, 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom());
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      oe        = ($urandom_range(0, 4) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
